// File: rtl/clint_timer_pkg.sv
// Shared definitions for the CLINT machine timer.
//   - 16-bit register offsets decoded from wb_adr_i[15:0]
//   - default mtimecmp reset value
//   - register-select enum plus decode and byte-lane merge helpers
package clint_timer_pkg;

   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   // All ones so mtime >= mtimecmp cannot hold until software programs it.
   localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      RegNone,
      RegCmpLo,
      RegCmpHi,
      RegTimeLo,
      RegTimeHi
   } clint_reg_e;

   // Word-aligned decode; byte offset bits [1:0] are ignored.
   function automatic clint_reg_e clint_decode(input logic [15:0] offset);
      logic [15:0] word_off;
      word_off = {offset[15:2], 2'b00};
      case (word_off)
         CLINT_MTIMECMP_LO: clint_decode = RegCmpLo;
         CLINT_MTIMECMP_HI: clint_decode = RegCmpHi;
         CLINT_MTIME_LO:    clint_decode = RegTimeLo;
         CLINT_MTIME_HI:    clint_decode = RegTimeHi;
         default:           clint_decode = RegNone;
      endcase
   endfunction

   // Replace the bytes of old_word whose lane enable is set.
   function automatic logic [31:0] clint_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick prescaler for the CLINT mtime counter.
//   clk, rst : clock and asynchronous active-high reset
//   tick_o   : high for one cycle out of every TICK_DIV (every cycle when TICK_DIV = 1)
// div_cnt counts 0..TICK_DIV-1 and wraps to 0 on the tick cycle.
module clint_prescaler #(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick_o
);

   localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

   logic [15:0] div_cnt_q, div_cnt_d;
   logic        tick;

   always_comb begin
      tick      = (div_cnt_q == LAST_CNT);
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= 16'd0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign tick_o = tick;

endmodule

// File: rtl/clint_timer.sv
// CLINT machine timer: 64-bit free-running mtime and 64-bit mtimecmp on a Wishbone slave.
//   clk, rst           : clock and asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i: Wishbone cycle, strobe, write enable
//   wb_adr_i           : byte address, only [15:0] decoded (base selected upstream)
//   wb_dat_i, wb_sel_i : write data and byte lane enables
//   wb_ack_o, wb_dat_o : one-cycle ack pulse and registered read data (0 when not acking)
//   timer_interrupt_o  : level, registered (mtime >= mtimecmp)
//   mtime_o            : current mtime, straight from the register
module clint_timer
   import clint_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 1,
   parameter logic [63:0] MTIMECMP_RST = CLINT_MTIMECMP_RST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic        wb_ack_o,
   output logic [31:0] wb_dat_o,
   output logic        timer_interrupt_o,
   output logic [63:0] mtime_o
);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        wb_ack_q, wb_ack_d;
   logic [31:0] wb_dat_q, wb_dat_d;
   logic        irq_q, irq_d;

   logic        tick;
   logic        req;
   logic        wr_en;
   logic        rd_en;
   logic        mtime_wr;
   clint_reg_e  reg_sel;

   // Upper address bits are decoded by the interconnect.
   logic        unused_adr;
   assign unused_adr = ^wb_adr_i[31:16];

   clint_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .tick_o (tick)
   );

   // Accept only when no ack is outstanding: a held strobe is served every other cycle.
   always_comb begin
      reg_sel  = clint_decode(wb_adr_i[15:0]);
      req      = wb_cyc_i & wb_stb_i & ~wb_ack_q;
      wr_en    = req & wb_we_i;
      rd_en    = req & ~wb_we_i;
      mtime_wr = wr_en & ((reg_sel == RegTimeLo) | (reg_sel == RegTimeHi));
      wb_ack_d = req;
   end

   // mtime: a bus write wins over the tick and suppresses that edge's increment.
   always_comb begin
      mtime_d = mtime_q;
      if (mtime_wr) begin
         if (reg_sel == RegTimeLo) begin
            mtime_d[31:0] = clint_merge(mtime_q[31:0], wb_dat_i, wb_sel_i);
         end else begin
            mtime_d[63:32] = clint_merge(mtime_q[63:32], wb_dat_i, wb_sel_i);
         end
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      if (wr_en) begin
         case (reg_sel)
            RegCmpLo: mtimecmp_d[31:0]  = clint_merge(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
            RegCmpHi: mtimecmp_d[63:32] = clint_merge(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
            default:  mtimecmp_d = mtimecmp_q;
         endcase
      end
   end

   // Read data comes from pre-update register values and is zero whenever ack is low.
   always_comb begin
      wb_dat_d = 32'd0;
      if (rd_en) begin
         case (reg_sel)
            RegCmpLo:  wb_dat_d = mtimecmp_q[31:0];
            RegCmpHi:  wb_dat_d = mtimecmp_q[63:32];
            RegTimeLo: wb_dat_d = mtime_q[31:0];
            RegTimeHi: wb_dat_d = mtime_q[63:32];
            default:   wb_dat_d = 32'd0;
         endcase
      end
   end

   always_comb begin
      irq_d = (mtime_q >= mtimecmp_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= MTIMECMP_RST;
         wb_ack_q   <= 1'b0;
         wb_dat_q   <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         wb_ack_q   <= wb_ack_d;
         wb_dat_q   <= wb_dat_d;
         irq_q      <= irq_d;
      end
   end

   assign wb_ack_o          = wb_ack_q;
   assign wb_dat_o          = wb_dat_q;
   assign timer_interrupt_o = irq_q;
   assign mtime_o           = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: two instances (TICK_DIV = 1 and 4) share one bus driver.
module tb_clint_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [31:0] adr = 32'd0;
   logic [31:0] wdat = 32'd0;
   logic [3:0]  sel = 4'd0;

   logic        ack1, ack4;
   logic [31:0] dat1, dat4;
   logic        irq1, irq4;
   logic [63:0] mtime1, mtime4;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;

   clint_timer #(
      .TICK_DIV (1)
   ) u_dut1 (
      .clk               (clk),
      .rst               (rst),
      .wb_cyc_i          (cyc),
      .wb_stb_i          (stb),
      .wb_we_i           (we),
      .wb_adr_i          (adr),
      .wb_dat_i          (wdat),
      .wb_sel_i          (sel),
      .wb_ack_o          (ack1),
      .wb_dat_o          (dat1),
      .timer_interrupt_o (irq1),
      .mtime_o           (mtime1)
   );

   clint_timer #(
      .TICK_DIV (4)
   ) u_dut4 (
      .clk               (clk),
      .rst               (rst),
      .wb_cyc_i          (cyc),
      .wb_stb_i          (stb),
      .wb_we_i           (we),
      .wb_adr_i          (adr),
      .wb_dat_i          (wdat),
      .wb_sel_i          (sel),
      .wb_ack_o          (ack4),
      .wb_dat_o          (dat4),
      .timer_interrupt_o (irq4),
      .mtime_o           (mtime4)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [63:0] mtime;
      logic [63:0] cmp;
      logic [31:0] edges;   // clock edges since reset release
      logic        ack;
      logic [31:0] dat;
      logic        irq;
   } mstate_t;

   mstate_t m1, m4;

   function automatic mstate_t model_reset();
      mstate_t s;
      s.mtime = 64'd0;
      s.cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      s.edges = 32'd0;
      s.ack   = 1'b0;
      s.dat   = 32'd0;
      s.irq   = 1'b0;
      return s;
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic mstate_t model_step(input mstate_t s, input int unsigned div);
      mstate_t     n;
      logic        accept;
      logic [15:0] a;
      logic        t_written;
      n         = s;
      accept    = cyc && stb && !s.ack;
      a         = {adr[15:2], 2'b00};
      t_written = 1'b0;
      n.edges   = s.edges + 32'd1;
      n.ack     = accept;
      n.dat     = 32'd0;
      n.irq     = (s.mtime >= s.cmp);
      if (accept && !we) begin
         if (a == 16'h4000) n.dat = s.cmp[31:0];
         if (a == 16'h4004) n.dat = s.cmp[63:32];
         if (a == 16'hBFF8) n.dat = s.mtime[31:0];
         if (a == 16'hBFFC) n.dat = s.mtime[63:32];
      end
      if (accept && we) begin
         if (a == 16'h4000) n.cmp[31:0]  = lanes(s.cmp[31:0], wdat, sel);
         if (a == 16'h4004) n.cmp[63:32] = lanes(s.cmp[63:32], wdat, sel);
         if (a == 16'hBFF8) begin
            n.mtime[31:0] = lanes(s.mtime[31:0], wdat, sel);
            t_written = 1'b1;
         end
         if (a == 16'hBFFC) begin
            n.mtime[63:32] = lanes(s.mtime[63:32], wdat, sel);
            t_written = 1'b1;
         end
      end
      // mtime advances on every div-th edge after reset unless written on that edge.
      if (!t_written && (int'(n.edges) % int'(div) == 0)) n.mtime = s.mtime + 64'd1;
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m1 <= model_reset();
         m4 <= model_reset();
      end else begin
         m1 <= model_step(m1, 1);
         m4 <= model_step(m4, 4);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("d1_ack", 64'(ack1), 64'(m1.ack));
         check("d1_dat", 64'(dat1), 64'(m1.dat));
         check("d1_irq", 64'(irq1), 64'(m1.irq));
         check("d1_mtime", mtime1, m1.mtime);
         check("d4_ack", 64'(ack4), 64'(m4.ack));
         check("d4_dat", 64'(dat4), 64'(m4.dat));
         check("d4_irq", 64'(irq4), 64'(m4.irq));
         check("d4_mtime", mtime4, m4.mtime);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ack(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         cycles(1);
         got = ack1;
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL %s: ack=%0b after 8 cycles, required 1", name, ack1);
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
      wait_ack("wr_ack");
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      cycles(1);
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      wait_ack("rd_ack");
      d = dat1;
      cyc = 1'b0; stb = 1'b0;
      cycles(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] rd;
      bit          hit;

      cycles(2);
      chk_en = 1'b1;
      check("rst_ack", 64'(ack1), 64'd0);
      check("rst_irq", 64'(irq1), 64'd0);
      check("rst_mtime", mtime1, 64'd0);
      rst = 1'b0;

      // Idle counting.
      cycles(10);
      check("idle10_mtime", mtime1, 64'd10);
      check("idle10_irq", 64'(irq1), 64'd0);
      cycles(2);
      check("idle12_div4", mtime4, 64'd3);

      // Compare match and clear.
      bus_write(32'h0000_4004, 32'd0, 4'hF);
      bus_write(32'h0000_4000, 32'd20, 4'hF);
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (mtime1 == 64'd20) hit = 1'b1;
         else cycles(1);
      end
      check("reach20", 64'(hit), 64'd1);
      check("irq_at20", 64'(irq1), 64'd0);
      cycles(1);
      check("irq_after20", 64'(irq1), 64'd1);
      bus_write(32'h0000_4000, 32'd100, 4'hF);
      check("irq_clear", 64'(irq1), 64'd0);

      // Carry from low to high word, then full wrap.
      bus_write(32'h0000_BFFC, 32'd0, 4'hF);
      bus_write(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF);
      check("carry", mtime1, 64'h0000_0001_0000_0000);
      bus_write(32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF);
      bus_write(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF);
      check("wrap", mtime1, 64'd0);

      // Byte-lane write on reset mtimecmp; strobe without cyc must be ignored.
      do_reset();
      bus_write(32'h0000_4001, 32'h0000_AB00, 4'b0010);
      stb = 1'b1; we = 1'b1; adr = 32'h0000_4000; wdat = 32'd0; sel = 4'hF;
      cycles(2);
      check("stb_only_ack", 64'(ack1), 64'd0);
      stb = 1'b0; we = 1'b0;
      cycles(1);
      bus_read(32'h0000_4000, rd);
      check("cmp_lo_byte", 64'(rd), 64'h0000_0000_FFFF_ABFF);
      bus_read(32'h0000_4004, rd);
      check("cmp_hi_byte", 64'(rd), 64'h0000_0000_FFFF_FFFF);

      // TICK_DIV = 4: write on a tick edge suppresses that increment.
      do_reset();
      cycles(12);
      check("div4_12", mtime4, 64'd3);
      cycles(3);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_BFF8; wdat = 32'd7; sel = 4'hF;
      cycles(1);
      check("div4_wr_ack", 64'(ack4), 64'd1);
      check("div4_wr7", mtime4, 64'd7);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      cycles(3);
      check("div4_hold7", mtime4, 64'd7);
      cycles(1);
      check("div4_inc8", mtime4, 64'd8);

      // Held read of unmapped offset, then reset during an ack.
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0010; sel = 4'hF;
      check("held_ack0", 64'(ack1), 64'd0);
      cycles(1);
      check("held_ack1", 64'(ack1), 64'd1);
      check("held_dat1", 64'(dat1), 64'd0);
      cycles(1);
      check("held_ack2", 64'(ack1), 64'd0);
      cycles(1);
      check("held_ack3", 64'(ack1), 64'd1);
      check("held_dat3", 64'(dat1), 64'd0);
      rst = 1'b1;
      #1;
      check("rst_mid_ack", 64'(ack1), 64'd0);
      check("rst_mid_mtime1", mtime1, 64'd0);
      check("rst_mid_mtime4", mtime4, 64'd0);
      cyc = 1'b0; stb = 1'b0;
      cycles(1);
      rst = 1'b0;
      cycles(3);
      check("post_rst_mtime", mtime1, 64'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Machine timer (CLINT subset) on the data-memory Wishbone bus: a 64-bit free-running mtime counter and a 64-bit mtimecmp compare register.
- Drives the CSR register file's timer interrupt input (timer_interrupt) and time/timeh source (mtime_i). It is the direct upstream feeder of those two inputs.
- The interconnect performs base-address selection. This block decodes only wb_adr_i[15:0].

Parameters:
- TICK_DIV, 1: mtime increments once every TICK_DIV clk cycles. Legal range is 1..65535.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp, chosen so no interrupt fires out of reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  byte address; only bits [15:0] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lane enables
- wb_ack_o  out  1  transfer acknowledge
- wb_dat_o  out  32  read data
- timer_interrupt_o  out  1  to csr_regfile timer_interrupt
- mtime_o  out  64  to csr_regfile mtime_i

Behaviour:
- Register map (offset from wb_adr_i[15:0]; bits [1:0] ignored):
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other offset: reads return 0 and writes are ignored, but the transfer is still acked.
- Reset values:
  - mtime = 0
  - mtimecmp = MTIMECMP_RST
  - prescaler count = 0
  - wb_ack_o = 0
  - wb_dat_o = 0
  - timer_interrupt_o = 0
- Prescaler:
  - div_cnt counts 0..TICK_DIV-1. tick = (div_cnt == TICK_DIV-1); div_cnt returns to 0 on the tick.
  - With TICK_DIV=1, tick is high every cycle.
- mtime update (priority order):
  1. A bus write to either mtime word: the selected bytes of that word take wb_dat_i; the other word holds. There is no increment on that edge, even if tick=1. div_cnt still advances normally.
  2. Otherwise, on tick: mtime <= mtime + 1, full 64-bit with carry from low to high. 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- mtimecmp: written bytewise per wb_sel_i; never changes otherwise.
- Bus handshake:
  - wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o. This gives a single-cycle ack pulse one cycle after the strobe. A held strobe is therefore acked every other cycle.
  - Writes take effect at the same edge that raises wb_ack_o. Exactly one write per ack.
  - Reads: wb_dat_o is registered at the ack edge from pre-update register values, so a read of mtime returns the value before that edge's increment. wb_dat_o = 0 in any cycle where ack is low.
  - Strobe without cyc: ignored.
- Interrupt:
  - timer_interrupt_o <= (mtime >= mtimecmp), unsigned 64-bit comparison on the currently held values. Latency is one cycle after the registers satisfy the condition.
  - The output is level, not latched. It clears one cycle after software raises mtimecmp above mtime or lowers mtime.
- Split-word hazard: software is responsible for the 32-bit write ordering (write mtimecmp hi = 0xFFFF_FFFF first). No hardware atomicity is provided.
- mtime_o: direct register output, zero latency.
- Reset asserted mid-transfer: all state returns to reset values immediately. A pending ack is lost and the master must retry.

Decomposition:
- Shared package (defines.sv) holds:
  - CLINT_MTIMECMP_LO / CLINT_MTIMECMP_HI / CLINT_MTIME_LO / CLINT_MTIME_HI offset constants (16-bit)
  - CLINT_MTIMECMP_RST default
- Sub-module clint_prescaler (div_cnt counter producing tick) is the natural split.
- Byte-lane merge and register map stay in clint_timer.

Test Plan:
- Reset release, TICK_DIV=1, no bus activity for 10 cycles -> mtime_o = 10, timer_interrupt_o = 0.
- Write mtimecmp hi = 0, then lo = 20 (sel = 4'hF) with mtime counting from 0 -> timer_interrupt_o rises exactly one cycle after mtime_o = 20; then write mtimecmp lo = 100 -> interrupt low one cycle after ack.
- Write mtime lo = 0xFFFF_FFFF, mtime hi = 0 -> next tick gives mtime_o = 64'h0000_0001_0000_0000. Then write hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFF -> next tick gives mtime_o = 0.
- Byte write to 0x4001 with sel = 4'b0010, wb_dat_i = 0x0000_AB00 on mtimecmp reset value -> mtimecmp = 64'hFFFF_FFFF_FFFF_ABFF; only byte 1 changed.
- TICK_DIV=4: 12 idle cycles -> mtime_o = 3. A write to mtime lo = 7 on a tick edge -> mtime_o = 7 (no +1); next increment 4 cycles later -> 8.
- Held cyc/stb read of unmapped offset 0x0010 for 4 cycles -> ack pattern 0,1,0,1 with wb_dat_o = 0. Assert rst during an ack -> wb_ack_o = 0 and mtime_o = 0 immediately.
